i2c_poll_sched: RTL and testbench



---
 rtl/i2c_poll_sched.sv | 279 +++++++++++++++++++++++++++
 tb/tb_i2c_poll_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_poll_sched.sv
// i2c_poll_sched -- polls two fixed I2C slaves in alternation through the
// single-byte I2C read engine and queues each returned byte in a small FIFO.
//
// Each poll waits POLL_PERIOD idle cycles, presents slave_addr, pulses start,
// then waits for done. The byte returned with done is queued as
// {slave_sel, byte}. If done does not arrive within TIMEOUT cycles of start,
// the sequencer sets timeout_err and halts until clr_err.
//
// Optional build macro: POLL_TIMESTAMP_EN
//   When defined, a 16-bit free-running cycle counter is captured into each
//   FIFO entry at the done cycle and presented on rd_ts.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              polling enable (level)
//   domain_i2c      security domain tag, passed through to rd_domain
//   start           one-cycle request pulse to the read engine (registered)
//   slave_addr      address presented to the read engine (registered)
//   done, read_data completion pulse and byte from the read engine
//   rd_en           pop FIFO head
//   rd_data         FIFO head {slave_sel, byte}, 0 when empty
//   rd_domain       = domain_i2c
//   fifo_empty/full/count  FIFO status
//   timeout_err     sticky: engine did not answer
//   overflow        sticky: result dropped because the FIFO was full
//   clr_err         clears both flags, releases HALT
//   rd_ts           (POLL_TIMESTAMP_EN only) head entry timestamp, 0 when empty
module i2c_poll_sched #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [6:0]  SADDR_A     = 7'h10,
  parameter logic [6:0]  SADDR_B     = 7'h20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          domain_i2c,
  output logic                          start,
  output logic [6:0]                    slave_addr,
  input  logic                          done,
  input  logic [7:0]                    read_data,
  input  logic                          rd_en,
  output logic [8:0]                    rd_data,
  output logic                          rd_domain,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err,
  output logic                          overflow,
  input  logic                          clr_err
`ifdef POLL_TIMESTAMP_EN
  ,
  output logic [15:0]                   rd_ts
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TCW = $clog2(TIMEOUT);
`ifdef POLL_TIMESTAMP_EN
  localparam int EW  = 25;
`else
  localparam int EW  = 9;
`endif

  localparam logic [PCW-1:0] PCNT_LOAD = PCW'(POLL_PERIOD - 1);
  localparam logic [PCW-1:0] PCNT_ONE  = PCW'(1);
  localparam logic [TCW-1:0] TCNT_LOAD = TCW'(TIMEOUT - 1);
  localparam logic [TCW-1:0] TCNT_ONE  = TCW'(1);
  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_PERIOD = 3'd1,
    ISSUE       = 3'd2,
    WAIT_DONE   = 3'd3,
    HALT        = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [PCW-1:0]   pcnt_r, pcnt_nxt_s;
  logic [TCW-1:0]   tcnt_r, tcnt_nxt_s;
  logic             sel_r, sel_nxt_s;
  logic             push_s, tmo_s;
  logic             start_r, timeout_err_r, overflow_r;
  logic [6:0]       slave_addr_r;

  logic [EW-1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_s, full_s, pop_s, wr_s, ovf_set_s;
  logic [EW-1:0]    entry_s;

`ifdef POLL_TIMESTAMP_EN
  logic [15:0]      ts_r;

  // Free-running timestamp counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_r <= 16'h0000;
    end else begin
      ts_r <= ts_r + 16'h0001;
    end
  end

  assign entry_s = {ts_r, sel_r, read_data};
`else
  assign entry_s = {sel_r, read_data};
`endif

  // Next-state logic: period countdown, request issue, done/timeout handling.
  always_comb begin
    state_nxt_s = state_r;
    pcnt_nxt_s  = pcnt_r;
    tcnt_nxt_s  = tcnt_r;
    sel_nxt_s   = sel_r;
    push_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && !timeout_err_r) begin
          state_nxt_s = WAIT_PERIOD;
          pcnt_nxt_s  = PCNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_PERIOD: begin
        if (!en) begin
          state_nxt_s = IDLE;
        end else if (pcnt_r == {PCW{1'b0}}) begin
          // Timeout counts from the cycle in which start is high.
          state_nxt_s = ISSUE;
          tcnt_nxt_s  = TCNT_LOAD;
        end else begin
          pcnt_nxt_s  = pcnt_r - PCNT_ONE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_DONE;
        tcnt_nxt_s  = tcnt_r - TCNT_ONE;
      end
      WAIT_DONE: begin
        if (done) begin
          push_s    = 1'b1;
          sel_nxt_s = ~sel_r;
          if (en) begin
            state_nxt_s = WAIT_PERIOD;
            pcnt_nxt_s  = PCNT_LOAD;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (tcnt_r == {TCW{1'b0}}) begin
          tmo_s       = 1'b1;
          sel_nxt_s   = ~sel_r;
          state_nxt_s = HALT;
        end else begin
          tcnt_nxt_s  = tcnt_r - TCNT_ONE;
        end
      end
      HALT: begin
        if (clr_err) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Sequencer state, counters and registered engine-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      pcnt_r       <= {PCW{1'b0}};
      tcnt_r       <= {TCW{1'b0}};
      sel_r        <= 1'b0;
      start_r      <= 1'b0;
      slave_addr_r <= SADDR_A;
    end else begin
      state_r <= state_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      sel_r   <= sel_nxt_s;
      start_r <= (state_nxt_s == ISSUE);
      // Address settles on entry to the wait period, well before start.
      if ((state_nxt_s == WAIT_PERIOD) && (state_r != WAIT_PERIOD)) begin
        slave_addr_r <= sel_nxt_s ? SADDR_B : SADDR_A;
      end
    end
  end

  // Sticky error flags; a new set wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (tmo_s) begin
        timeout_err_r <= 1'b1;
      end else if (clr_err) begin
        timeout_err_r <= 1'b0;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == DEPTH_C);
  assign pop_s     = rd_en && !empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_s      = push_s && (!full_s || pop_s);
  assign ovf_set_s = push_s && full_s && !pop_s;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Head presentation, forced to zero when empty.
  always_comb begin
    rd_data = 9'h000;
`ifdef POLL_TIMESTAMP_EN
    rd_ts   = 16'h0000;
`endif
    if (!empty_s) begin
      rd_data = mem_r[rd_ptr_r][8:0];
`ifdef POLL_TIMESTAMP_EN
      rd_ts   = mem_r[rd_ptr_r][24:9];
`endif
    end else begin
      rd_data = 9'h000;
    end
  end

  assign start       = start_r;
  assign slave_addr  = slave_addr_r;
  assign timeout_err = timeout_err_r;
  assign overflow    = overflow_r;
  assign fifo_empty  = empty_s;
  assign fifo_full   = full_s;
  assign fifo_count  = count_r;
  assign rd_domain   = domain_i2c;

endmodule

// File: tb/tb_i2c_poll_sched.sv
// Self-checking bench for i2c_poll_sched (POLL_PERIOD=4, TIMEOUT=16,
// FIFO_DEPTH=4). Expected FIFO entries are queued when the engine model
// answers; a negedge monitor compares each popped head against the queue.
module tb_i2c_poll_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        domain_i2c = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  read_data = 8'h00;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic        start;
  logic [6:0]  slave_addr;
  logic [8:0]  rd_data;
  logic        rd_domain;
  logic        fifo_empty;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        timeout_err;
  logic        overflow;
`ifdef POLL_TIMESTAMP_EN
  logic [15:0] rd_ts;
  logic [15:0] tb_cyc;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [24:0] exp_q[$];

  i2c_poll_sched #(
    .POLL_PERIOD(4), .TIMEOUT(16), .FIFO_DEPTH(4),
    .SADDR_A(7'h10), .SADDR_B(7'h20)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .domain_i2c(domain_i2c),
    .start(start), .slave_addr(slave_addr), .done(done),
    .read_data(read_data), .rd_en(rd_en), .rd_data(rd_data),
    .rd_domain(rd_domain), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .timeout_err(timeout_err), .overflow(overflow),
    .clr_err(clr_err)
`ifdef POLL_TIMESTAMP_EN
    , .rd_ts(rd_ts)
`endif
  );

  always #5 clk = ~clk;

`ifdef POLL_TIMESTAMP_EN
  // Reference cycle counter for expected timestamps.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 16'h0000;
    else     tb_cyc <= tb_cyc + 16'h0001;
  end
`endif

  function automatic logic [15:0] ts_now();
`ifdef POLL_TIMESTAMP_EN
    return tb_cyc;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string nm, input int exp_ticks, input logic [6:0] exp_addr);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!start && k < 200);
    chk({nm, "_latency"}, 32'(k), 32'(exp_ticks));
    chk({nm, "_addr"}, 32'(slave_addr), 32'(exp_addr));
  endtask

  task automatic no_start(input string nm, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (start) s++;
    end
    chk(nm, 32'(s), 32'd0);
  endtask

  task automatic reply(input int dly, input logic [7:0] d, input logic sel, input bit push_exp);
    repeat (dly) tick();
    done = 1'b1;
    read_data = d;
    if (push_exp) exp_q.push_back({ts_now(), sel, d});
    tick();
    done = 1'b0;
    read_data = 8'h00;
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  // Scoreboard monitor: compare the head whenever it is being popped.
  always @(negedge clk) begin
    logic [24:0] e;
    if (!rst && rd_en && !fifo_empty) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e[8:0]));
`ifdef POLL_TIMESTAMP_EN
        chk("rd_ts", 32'(rd_ts), 32'(e[24:9]));
`endif
      end
    end
  end

  initial begin
    repeat (3) tick();
    // Reset values
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_addr", 32'(slave_addr), 32'h10);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    domain_i2c = 1'b1;
    #1 chk("domain_hi", 32'(rd_domain), 32'd1);
    domain_i2c = 1'b0;
    #1 chk("domain_lo", 32'(rd_domain), 32'd0);
    rst = 1'b0;
    tick();

    // Two polls, alternate slaves, then en dropped in WAIT_PERIOD
    en = 1'b1;
    wait_start("t1_first", 5, 7'h10);
    reply(10, 8'hA5, 1'b0, 1'b1);
    wait_start("t1_second", 4, 7'h20);
    reply(10, 8'h3C, 1'b1, 1'b1);
    en = 1'b0;
    no_start("t1_en_drop_period", 20);
    chk("t1_count", 32'(fifo_count), 32'd2);
    pop_n(2);
    chk("t1_empty", 32'(fifo_empty), 32'd1);

    // en dropped during WAIT_DONE: byte still queued, no new start
    en = 1'b1;
    wait_start("t2", 5, 7'h10);
    en = 1'b0;
    reply(6, 8'h5A, 1'b0, 1'b1);
    no_start("t2_en_drop_done", 20);
    chk("t2_count", 32'(fifo_count), 32'd1);
    pop_n(1);

    // Timeout, halt, stray done ignored, clear and resume with other slave
    en = 1'b1;
    wait_start("t3", 5, 7'h20);
    begin
      int k;
      k = 0;
      do begin
        tick();
        k++;
      end while (!timeout_err && k < 100);
      chk("t3_tmo_latency", 32'(k), 32'd16);
    end
    no_start("t3_halt_no_start", 30);
    done = 1'b1;
    read_data = 8'hEE;
    tick();
    done = 1'b0;
    read_data = 8'h00;
    chk("t3_stray_count", 32'(fifo_count), 32'd0);
    chk("t3_stray_ovf", 32'(overflow), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_tmo_clr", 32'(timeout_err), 32'd0);
    wait_start("t3_resume", 5, 7'h10);
    reply(3, 8'hC3, 1'b0, 1'b1);
    en = 1'b0;
    pop_n(1);

    // Overflow: five polls into a 4-deep FIFO
    en = 1'b1;
    wait_start("t4_1", 5, 7'h20);
    reply(2, 8'h11, 1'b1, 1'b1);
    wait_start("t4_2", 4, 7'h10);
    reply(2, 8'h22, 1'b0, 1'b1);
    wait_start("t4_3", 4, 7'h20);
    reply(2, 8'h33, 1'b1, 1'b1);
    wait_start("t4_4", 4, 7'h10);
    reply(2, 8'h44, 1'b0, 1'b1);
    wait_start("t4_5", 4, 7'h20);
    reply(2, 8'h55, 1'b1, 1'b0);
    chk("t4_full", 32'(fifo_full), 32'd1);
    chk("t4_count", 32'(fifo_count), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_head", 32'(rd_data), 32'h111);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    // Push and pop together while full
    wait_start("t4_6", 3, 7'h10);
    repeat (2) tick();
    done = 1'b1;
    read_data = 8'h66;
    rd_en = 1'b1;
    exp_q.push_back({ts_now(), 1'b0, 8'h66});
    tick();
    done = 1'b0;
    read_data = 8'h00;
    rd_en = 1'b0;
    en = 1'b0;
    chk("t4_pp_count", 32'(fifo_count), 32'd4);
    chk("t4_pp_ovf", 32'(overflow), 32'd0);
    chk("t4_pp_full", 32'(fifo_full), 32'd1);
    pop_n(4);
    chk("t4_drained", 32'(fifo_empty), 32'd1);
    pop_n(1);
    chk("t4_pop_empty", 32'(fifo_count), 32'd0);

    // Asynchronous reset mid WAIT_DONE with 3 entries
    en = 1'b1;
    wait_start("t5_1", 5, 7'h20);
    reply(2, 8'h71, 1'b1, 1'b0);
    wait_start("t5_2", 4, 7'h10);
    reply(2, 8'h72, 1'b0, 1'b0);
    wait_start("t5_3", 4, 7'h20);
    reply(2, 8'h73, 1'b1, 1'b0);
    wait_start("t5_4", 4, 7'h10);
    repeat (3) tick();
    chk("t5_pre_count", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_start", 32'(start), 32'd0);
    chk("t5_addr", 32'(slave_addr), 32'h10);
    chk("t5_empty", 32'(fifo_empty), 32'd1);
    chk("t5_full", 32'(fifo_full), 32'd0);
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_rd_data", 32'(rd_data), 32'd0);
    chk("t5_tmo", 32'(timeout_err), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    done = 1'b1;
    read_data = 8'h99;
    tick();
    done = 1'b0;
    read_data = 8'h00;
    chk("t5_late_done", 32'(fifo_count), 32'd0);
    no_start("t5_idle", 10);

`ifdef POLL_TIMESTAMP_EN
    chk("ts_empty", 32'(rd_ts), 32'd0);
`endif
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
